// File: rtl/move_scanner_if.sv
// move_scanner_if: groups the move scanner's controller, board-memory and flipper signals.
//   Controller side : start, s_addr_in, player -> busy_o, done_o, valid_o
//   Memory side     : addr_out, ctrl_mem -> data_in
//   Flipper side    : ld_o, start_flip_o, step_o, step_sign_o, skip_flip_o -> f_done_in
// master drives the scanner's inputs; slave is the scanner itself.
interface move_scanner_if;
    logic       start;
    logic [6:0] s_addr_in;
    logic       player;
    logic [1:0] data_in;
    logic       f_done_in;
    logic [6:0] addr_out;
    logic       ctrl_mem;
    logic       ld_o;
    logic       start_flip_o;
    logic [4:0] step_o;
    logic       step_sign_o;
    logic       skip_flip_o;
    logic       busy_o;
    logic       done_o;
    logic       valid_o;

    modport master (
        output start, s_addr_in, player, data_in, f_done_in,
        input  addr_out, ctrl_mem, ld_o, start_flip_o, step_o, step_sign_o,
               skip_flip_o, busy_o, done_o, valid_o
    );

    modport slave (
        input  start, s_addr_in, player, data_in, f_done_in,
        output addr_out, ctrl_mem, ld_o, start_flip_o, step_o, step_sign_o,
               skip_flip_o, busy_o, done_o, valid_o
    );
endinterface

// File: rtl/move_scanner.sv
// move_scanner: checks a target cell is empty, then scans the 8 directions of an
// 8x8 board, hands each direction to the flipper and reports whether the move was legal.
//   clock  : system clock
//   reset  : asynchronous, active-low reset
//   bus    : move_scanner_if.slave (start/addr/player in, memory port, flipper
//            handshake, busy/done/valid out)
module move_scanner (
    input logic           clock,
    input logic           reset,
    move_scanner_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ORG_RD, ORG_WAIT, ORG_EVAL, DIR_INIT, STEP, RD_WAIT, RD_EVAL,
        LOAD, FIRE, WAIT_FLIP, NEXT_DIR, DONE
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] org_q, org_d, cur_q, cur_d, addr_q, addr_d;
    logic [2:0] dir_q, dir_d, cnt_q, cnt_d;
    logic       player_q, player_d, legal_q, legal_d, flip_q, flip_d, valid_q, valid_d;
    logic [4:0] step;
    logic [2:0] col, row;
    logic [1:0] own, opp;
    logic       edge_ok, handoff;

    // Direction index: bit 0 selects subtract; bits [2:1] select the step magnitude.
    always_comb begin
        col     = cur_q[2:0];
        row     = cur_q[5:3];
        step    = (dir_q[2:1] == 2'd0) ? 5'd1 :
                  (dir_q[2:1] == 2'd1) ? 5'd8 :
                  (dir_q[2:1] == 2'd2) ? 5'd9 : 5'd7;
        own     = player_q ? 2'b10 : 2'b01;
        opp     = player_q ? 2'b01 : 2'b10;
        edge_ok = 1'b0;
        case (dir_q)
            3'd0: edge_ok = (col != 3'd7);
            3'd1: edge_ok = (col != 3'd0);
            3'd2: edge_ok = (row != 3'd7);
            3'd3: edge_ok = (row != 3'd0);
            3'd4: edge_ok = (row != 3'd7) && (col != 3'd7);
            3'd5: edge_ok = (row != 3'd0) && (col != 3'd0);
            3'd6: edge_ok = (row != 3'd7) && (col != 3'd0);
            default: edge_ok = (row != 3'd0) && (col != 3'd7);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        org_d    = org_q;
        cur_d    = cur_q;
        addr_d   = addr_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        player_d = player_q;
        legal_d  = legal_q;
        flip_d   = flip_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                org_d    = bus.s_addr_in;
                addr_d   = bus.s_addr_in;
                player_d = bus.player;
                legal_d  = 1'b0;
                valid_d  = 1'b0;
                state_d  = ORG_RD;
            end
            ORG_RD:   state_d = ORG_WAIT;
            ORG_WAIT: state_d = ORG_EVAL;
            ORG_EVAL: begin
                dir_d   = 3'd0;
                state_d = (bus.data_in != 2'b00) ? DONE : DIR_INIT;
            end
            DIR_INIT: begin
                cur_d   = org_q;
                cnt_d   = 3'd0;
                state_d = STEP;
            end
            // A failing edge test ends the direction before any read, so cur never wraps.
            STEP: if (edge_ok) begin
                cur_d   = dir_q[0] ? cur_q - 7'(step) : cur_q + 7'(step);
                addr_d  = cur_d;
                state_d = RD_WAIT;
            end else begin
                flip_d  = 1'b0;
                state_d = LOAD;
            end
            RD_WAIT: state_d = RD_EVAL;
            RD_EVAL: if (bus.data_in == opp) begin
                cnt_d   = cnt_q + 3'd1;
                state_d = STEP;
            end else begin
                flip_d  = (bus.data_in == own) && (cnt_q != 3'd0);
                state_d = LOAD;
            end
            LOAD: state_d = FIRE;
            FIRE: state_d = WAIT_FLIP;
            WAIT_FLIP: if (bus.f_done_in) begin
                legal_d = legal_q | flip_q;
                state_d = NEXT_DIR;
            end
            NEXT_DIR: if (dir_q == 3'd7) begin
                valid_d = legal_q;
                state_d = DONE;
            end else begin
                dir_d   = dir_q + 3'd1;
                state_d = DIR_INIT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            org_q    <= '0;
            cur_q    <= '0;
            addr_q   <= '0;
            dir_q    <= '0;
            cnt_q    <= '0;
            player_q <= 1'b0;
            legal_q  <= 1'b0;
            flip_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            org_q    <= org_d;
            cur_q    <= cur_d;
            addr_q   <= addr_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            player_q <= player_d;
            legal_q  <= legal_d;
            flip_q   <= flip_d;
            valid_q  <= valid_d;
        end
    end

    // Flipper-facing fields are only driven during the load/fire/wait handoff.
    assign handoff          = (state_q == LOAD) || (state_q == FIRE) || (state_q == WAIT_FLIP);
    assign bus.addr_out     = addr_q;
    assign bus.ctrl_mem     = (state_q inside {ORG_RD, ORG_WAIT, ORG_EVAL, DIR_INIT, STEP,
                                               RD_WAIT, RD_EVAL, NEXT_DIR});
    assign bus.ld_o         = (state_q == LOAD);
    assign bus.start_flip_o = (state_q == FIRE);
    assign bus.step_o       = handoff ? step : 5'd0;
    assign bus.step_sign_o  = handoff && dir_q[0];
    assign bus.skip_flip_o  = handoff && !flip_q;
    assign bus.busy_o       = (state_q != IDLE) && (state_q != DONE);
    assign bus.done_o       = (state_q == DONE);
    assign bus.valid_o      = valid_q;
endmodule

// File: tb/tb_move_scanner.sv
// tb_move_scanner: directed bench for move_scanner with a synchronous board RAM model
// and a behavioural flipper that answers each start_flip_o with a done pulse.
module tb_move_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    move_scanner_if ms_if ();
    move_scanner dut (.clock(clk), .reset(rst_n), .bus(ms_if.slave));

    logic [1:0]  mem [64];
    int          checks = 0, failures = 0;
    int          n_ld = 0, n_fire = 0, n_skip = 0, n_done = 0, fire_bad = 0, flip_delay = 2;
    logic [4:0]  ns_step = '0;
    logic        ns_sign = 1'b0;
    logic [6:0]  cur_org = '0;
    logic        cur_pl = 1'b0;
    logic [63:0] seen = '0;
    logic        busy_prev = 1'b0;
    logic [6:0]  ld_vec = '0;
    logic [19:0] ov;

    assign ov = {ms_if.addr_out, ms_if.ctrl_mem, ms_if.ld_o, ms_if.start_flip_o, ms_if.step_o,
                 ms_if.step_sign_o, ms_if.skip_flip_o, ms_if.busy_o, ms_if.done_o, ms_if.valid_o};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) ms_if.data_in <= mem[ms_if.addr_out[5:0]];

    always @(negedge clk) begin
        if (ms_if.busy_o && !busy_prev)
            seen = ms_if.ctrl_mem ? (64'd1 << ms_if.addr_out[5:0]) : 64'd0;
        else if (ms_if.ctrl_mem)
            seen = seen | (64'd1 << ms_if.addr_out[5:0]);
        busy_prev = ms_if.busy_o;
        if (ms_if.ld_o) begin
            n_ld++;
            ld_vec = {ms_if.step_o, ms_if.step_sign_o, ms_if.skip_flip_o};
            if (ms_if.skip_flip_o) n_skip++;
            else begin
                ns_step = ms_if.step_o;
                ns_sign = ms_if.step_sign_o;
            end
        end
        if (ms_if.start_flip_o) begin
            n_fire++;
            if ({ms_if.step_o, ms_if.step_sign_o, ms_if.skip_flip_o} != ld_vec) fire_bad++;
        end
        if (ms_if.done_o) n_done++;
    end

    initial begin
        logic       sk, sg;
        int         st, c;
        logic [1:0] own, opp;
        ms_if.f_done_in = 1'b0;
        forever begin
            @(negedge clk);
            if (ms_if.start_flip_o) begin
                sk = ms_if.skip_flip_o;
                sg = ms_if.step_sign_o;
                st = int'(ms_if.step_o);
                repeat (flip_delay) @(negedge clk);
                if (!sk) begin
                    own = cur_pl ? 2'b10 : 2'b01;
                    opp = cur_pl ? 2'b01 : 2'b10;
                    c = int'(cur_org);
                    mem[c] = own;
                    for (int k = 0; k < 8; k++) begin
                        c = sg ? c - st : c + st;
                        if (c < 0 || c > 63) break;
                        if (mem[c] == opp) mem[c] = own;
                        else break;
                    end
                end
                ms_if.f_done_in = 1'b1;
                @(negedge clk);
                ms_if.f_done_in = 1'b0;
            end
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 64; i++) mem[i] = 2'b00;
    endtask

    task automatic opening_board();
        clear_board();
        mem[27] = 2'b10;
        mem[36] = 2'b10;
        mem[28] = 2'b01;
        mem[35] = 2'b01;
    endtask

    task automatic run_move(input logic [6:0] org, input logic pl, output int lat);
        cur_org = org;
        cur_pl  = pl;
        @(negedge clk);
        ms_if.start     = 1'b1;
        ms_if.s_addr_in = org;
        ms_if.player    = pl;
        @(negedge clk);
        ms_if.start = 1'b0;
        lat = 1;
        while (!ms_if.done_o && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", ms_if.done_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, b_ld, b_fire, b_skip, b_done, b_fb, bad, k, cnt;
        logic [19:0] snap;
        ms_if.start     = 1'b0;
        ms_if.s_addr_in = '0;
        ms_if.player    = 1'b0;
        clear_board();
        repeat (3) @(negedge clk);
        check("reset_outputs", ov, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", ov, 0);

        // Opening board, black at 19: only S flips.
        opening_board();
        b_ld = n_ld; b_fire = n_fire; b_skip = n_skip; b_fb = fire_bad;
        run_move(7'd19, 1'b0, lat);
        check("t1_valid", ms_if.valid_o, 1);
        check("t1_ld_count", n_ld - b_ld, 8);
        check("t1_fire_count", n_fire - b_fire, 8);
        check("t1_skip_count", n_skip - b_skip, 7);
        check("t1_flip_step", ns_step, 8);
        check("t1_flip_sign", ns_sign, 0);
        check("t1_fire_stable", fire_bad - b_fb, 0);
        check("t1_mem27", mem[27], 2'b01);
        check("t1_mem19", mem[19], 2'b01);
        @(negedge clk);
        check("t1_valid_hold", ms_if.valid_o, 1);
        check("t1_busy_low", ms_if.busy_o, 0);

        // Occupied target.
        opening_board();
        b_ld = n_ld; b_fire = n_fire;
        run_move(7'd27, 1'b0, lat);
        check("t2_latency", lat, 4);
        check("t2_valid", ms_if.valid_o, 0);
        check("t2_ld_count", n_ld - b_ld, 0);
        check("t2_fire_count", n_fire - b_fire, 0);

        // Corner 7 on an empty board: only 6, 14, 15 are read besides the origin.
        clear_board();
        b_skip = n_skip;
        run_move(7'd7, 1'b0, lat);
        check("t3_valid", ms_if.valid_o, 0);
        check("t3_read_set", seen, (64'd1 << 6) | (64'd1 << 7) | (64'd1 << 14) | (64'd1 << 15));
        check("t3_skip_count", n_skip - b_skip, 8);
        check("t3_mem7", mem[7], 2'b00);

        // Six opponents along row 0.
        clear_board();
        for (int i = 1; i < 7; i++) mem[i] = 2'b10;
        mem[7] = 2'b01;
        b_skip = n_skip;
        run_move(7'd0, 1'b0, lat);
        check("t4_valid", ms_if.valid_o, 1);
        check("t4_flip_step", ns_step, 1);
        check("t4_flip_sign", ns_sign, 0);
        check("t4_skip_count", n_skip - b_skip, 7);
        cnt = 0;
        for (int i = 0; i < 8; i++) if (mem[i] == 2'b01) cnt++;
        check("t4_row_black", cnt, 8);

        // Flipper stalls in WAIT_FLIP; a stray start is ignored.
        opening_board();
        flip_delay = 25;
        cur_org = 7'd19;
        cur_pl  = 1'b0;
        b_ld = n_ld;
        @(negedge clk);
        ms_if.start = 1'b1; ms_if.s_addr_in = 7'd19; ms_if.player = 1'b0;
        @(negedge clk);
        ms_if.start = 1'b0;
        k = 0;
        while (!ms_if.start_flip_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_fire_seen", ms_if.start_flip_o, 1);
        @(negedge clk);
        snap = ov;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov != snap) bad++;
            if (i == 5) begin ms_if.start = 1'b1; ms_if.s_addr_in = 7'd0; end
            if (i == 6) ms_if.start = 1'b0;
        end
        flip_delay = 2;
        check("t5_stable", bad, 0);
        check("t5_no_next_ld", n_ld - b_ld, 1);
        k = 0;
        while (!ms_if.done_o && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("t5_done_seen", ms_if.done_o, 1);
        check("t5_valid", ms_if.valid_o, 1);
        check("t5_ld_count", n_ld - b_ld, 8);
        check("t5_mem19", mem[19], 2'b01);
        check("t5_mem0", mem[0], 2'b00);

        // Reset while waiting on the first scan read.
        opening_board();
        cur_org = 7'd19;
        @(negedge clk);
        ms_if.start = 1'b1; ms_if.s_addr_in = 7'd19; ms_if.player = 1'b0;
        @(negedge clk);
        ms_if.start = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_rd_wait", {ms_if.ctrl_mem, ms_if.addr_out}, {1'b1, 7'd20});
        b_done = n_done;
        #1 rst_n = 1'b0;
        #1 check("t6_reset_outputs", ov, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_idle_outputs", ov, 0);
        check("t6_no_done", n_done - b_done, 0);
        b_ld = n_ld;
        run_move(7'd19, 1'b0, lat);
        check("t6_valid", ms_if.valid_o, 1);
        check("t6_ld_count", n_ld - b_ld, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
